// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// parity-mode constants and a frame length helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned PARITY_EVEN = 0;
   localparam int unsigned PARITY_ODD  = 1;

   // Bit times per frame: start + data + optional parity + stop bits.
   function automatic int unsigned frame_len(input int unsigned data_w,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
      return 1 + data_w + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side valid/ready handshake into the buffered UART transmitter.
interface uart_tx_buffered_if #(
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] Data_In;
   logic              Tx_valid;
   logic              Tx_ready;

   modport master (output Data_In, output Tx_valid, input Tx_ready);
   modport slave  (input Data_In, input Tx_valid, output Tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; head word is shown
// combinationally on rdata_o while the FIFO is non-empty.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames with optional parity
// and 1 or 2 stop bits, sent back-to-back while words are queued.
module uart_tx_buffered #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        Baud_Clk,
   input  logic                        Reset,
   uart_tx_buffered_if.slave           tx,
   output logic                        Tx_dataOut,
   output logic                        Tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] Fifo_count
);

   import uart_pkg::*;

   localparam int unsigned CNT_W = $clog2(frame_len(DATA_W, PARITY_EN, STOP_BITS));

   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_START  = START;
   localparam logic [2:0] ST_DATA   = DATA;
   localparam logic [2:0] ST_PARITY = PARITY;
   localparam logic [2:0] ST_STOP   = STOP;

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              par_q, par_d;
   logic              line_q, line_d;
   logic              busy_q, busy_d;

   logic              push, pop, load, full, empty;
   logic [DATA_W-1:0] head;

   // Ready comes from the registered count only, so a same-edge pop never
   // lets a full FIFO accept.
   assign tx.Tx_ready = !full;
   assign push        = tx.Tx_valid && !full;

   uart_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (Baud_Clk),
      .rst_i   (Reset),
      .push_i  (push),
      .wdata_i (tx.Data_In),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (Fifo_count)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      line_d  = line_q;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            line_d = 1'b1;
            if (!empty) load = 1'b1;
         end
         ST_START: begin
            line_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = '0;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               cnt_d = '0;
               if (PARITY_EN != 0) begin
                  line_d  = par_q;
                  state_d = ST_PARITY;
               end else begin
                  line_d  = 1'b1;
                  state_d = ST_STOP;
               end
            end else begin
               line_d  = shreg_q[0];
               shreg_d = shreg_q >> 1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_PARITY: begin
            line_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_STOP;
         end
         ST_STOP: begin
            if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
               if (!empty) begin
                  load = 1'b1;
               end else begin
                  line_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               line_d = 1'b1;
               cnt_d  = cnt_q + 1'b1;
            end
         end
         default: begin
            line_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      // Parity is latched from the popped word, not from the shifting copy.
      if (load) begin
         shreg_d = head;
         par_d   = (^head) ^ 1'(PARITY_ODD);
         line_d  = 1'b0;
         state_d = ST_START;
      end

      pop    = load;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Baud_Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         line_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         line_q  <= line_d;
         busy_q  <= busy_d;
      end
   end

   assign Tx_dataOut = line_q;
   assign Tx_busy    = busy_q;

endmodule
